// File: rtl/data_mem.sv
// Word-organised data memory: 1-cycle registered reads, write-on-accept, range/alignment checks.
// Optional zero-fill engine (wipe after reset or on wipe_req) enabled by DMEM_WIPE_EN.
module data_mem #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_data_r_en,
  input  logic [31:0] mem_data_r_addr,
  output logic [31:0] mem_data_r_data,
  input  logic        mem_data_w_en,
  input  logic [31:0] mem_data_w_addr,
  input  logic [31:0] mem_data_w_data,
  input  logic        wipe_req,
  output logic        busy,
  output logic        err_misaligned,
  output logic        err_range
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           r_off, w_off;
  logic                  r_mis, r_oor, w_mis, w_oor, r_acc, w_acc;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx;
  logic [31:0]           r_data_q, r_data_d;
  logic                  mis_q, mis_d, rng_q, rng_d;
  logic                  wipe_we;
  logic [ADDR_WIDTH-1:0] wipe_idx;

  // Offsets below BASE_ADDR wrap high and land outside the window.
  assign r_off = mem_data_r_addr - BASE_ADDR;
  assign w_off = mem_data_w_addr - BASE_ADDR;
  assign r_mis = mem_data_r_addr[1:0] != 2'b00;
  assign w_mis = mem_data_w_addr[1:0] != 2'b00;
  assign r_oor = (r_off >> (ADDR_WIDTH + 2)) != 32'd0;
  assign w_oor = (w_off >> (ADDR_WIDTH + 2)) != 32'd0;
  assign r_idx = r_off[ADDR_WIDTH+1:2];
  assign w_idx = w_off[ADDR_WIDTH+1:2];
  assign r_acc = mem_data_r_en & ~busy;
  assign w_acc = mem_data_w_en & ~busy;

`ifdef DMEM_WIPE_EN
  typedef enum logic {IDLE, WIPE} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WIPE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (wipe_req) state_d = WIPE;
      WIPE: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == WIPE);
  // Held off while rst is high so reset itself never touches the array.
  assign wipe_we  = busy & ~rst;
  assign wipe_idx = cnt_q;
`else
  logic unused_wipe_req;
  assign unused_wipe_req = wipe_req;
  assign busy            = 1'b0;
  assign wipe_we         = 1'b0;
  assign wipe_idx        = '0;
`endif

  always_ff @(posedge clk) begin
    if (wipe_we)
      mem_q[wipe_idx] <= '0;
    else if (w_acc && !w_mis && !w_oor)
      mem_q[w_idx] <= mem_data_w_data;
  end

  // Read samples the old word, so a same-cycle write to it is seen next read.
  always_comb begin
    r_data_d = r_data_q;
    mis_d    = 1'b0;
    rng_d    = 1'b0;
    if (r_acc) begin
      if (r_mis) begin
        r_data_d = '0;
        mis_d    = 1'b1;
      end else if (r_oor) begin
        r_data_d = '0;
        rng_d    = 1'b1;
      end else begin
        r_data_d = mem_q[r_idx];
      end
    end
    if (w_acc) begin
      if (w_mis)      mis_d = 1'b1;
      else if (w_oor) rng_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_q <= '0;
      mis_q    <= 1'b0;
      rng_q    <= 1'b0;
    end else begin
      r_data_q <= r_data_d;
      mis_q    <= mis_d;
      rng_q    <= rng_d;
    end
  end

  assign mem_data_r_data = r_data_q;
  assign err_misaligned  = mis_q;
  assign err_range       = rng_q;
endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem; wipe-engine scenarios run when DMEM_WIPE_EN is defined.
module tb_data_mem;
`ifdef DMEM_WIPE_EN
  localparam int AW = 4;
`else
  localparam int AW = 10;
`endif
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] OOR   = 32'(4 * DEPTH);
  localparam logic [31:0] LAST  = 32'(4 * DEPTH - 4);

  logic        clk = 1'b0, rst = 1'b1;
  logic        r_en = 1'b0, w_en = 1'b0, wipe_req = 1'b0;
  logic [31:0] r_addr = '0, w_addr = '0, w_data = '0;
  logic [31:0] r_data;
  logic        busy, err_mis, err_rng;
  int          checks = 0, errors = 0;
  int          n;

  data_mem #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_data_r_en(r_en), .mem_data_r_addr(r_addr), .mem_data_r_data(r_data),
    .mem_data_w_en(w_en), .mem_data_w_addr(w_addr), .mem_data_w_data(w_data),
    .wipe_req(wipe_req), .busy(busy),
    .err_misaligned(err_mis), .err_range(err_rng)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    r_en = 1'b1; r_addr = a;
    tick();
    r_en = 1'b0;
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    tick();
    chk("rst_rdata", r_data, 32'h0);
    chk("rst_errmis", {31'h0, err_mis}, 32'h0);
    chk("rst_errrng", {31'h0, err_rng}, 32'h0);
`ifdef DMEM_WIPE_EN
    chk("rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    wait_busy(n);
    chk("init_wipe_len", n, DEPTH);
`else
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
`endif

    // basic write/read
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    chk("basic_rd", r_data, 32'hDEAD_BEEF);
    chk("basic_mis", {31'h0, err_mis}, 32'h0);
    chk("basic_rng", {31'h0, err_rng}, 32'h0);
    tick();
    chk("hold_rd", r_data, 32'hDEAD_BEEF);

    // same-word collision: read-before-write
    wr(32'h10, 32'h1111_1111);
    r_en = 1'b1; r_addr = 32'h10;
    w_en = 1'b1; w_addr = 32'h10; w_data = 32'h2222_2222;
    tick();
    r_en = 1'b0; w_en = 1'b0;
    chk("coll_old", r_data, 32'h1111_1111);
    rd(32'h10);
    chk("coll_new", r_data, 32'h2222_2222);

    // misaligned read and write
    rd(32'h13);
    chk("mis_rd_data", r_data, 32'h0);
    chk("mis_rd_flag", {31'h0, err_mis}, 32'h1);
    chk("mis_rd_rng", {31'h0, err_rng}, 32'h0);
    tick();
    chk("mis_pulse_end", {31'h0, err_mis}, 32'h0);
    wr(32'h12, 32'hFFFF_FFFF);
    chk("mis_wr_flag", {31'h0, err_mis}, 32'h1);
    rd(32'h10);
    chk("mis_wr_nochg", r_data, 32'h2222_2222);
    chk("mis_wr_end", {31'h0, err_mis}, 32'h0);

    // out of range write must not alias to word 0
    wr(32'h0, 32'hA5A5_A5A5);
    wr(OOR, 32'h5A5A_5A5A);
    chk("oor_wr_rng", {31'h0, err_rng}, 32'h1);
    chk("oor_wr_mis", {31'h0, err_mis}, 32'h0);
    tick();
    chk("oor_pulse_end", {31'h0, err_rng}, 32'h0);
    rd(32'h0);
    chk("oor_no_alias", r_data, 32'hA5A5_A5A5);
    rd(OOR);
    chk("oor_rd_data", r_data, 32'h0);
    chk("oor_rd_rng", {31'h0, err_rng}, 32'h1);
    rd(32'hFFFF_FFFC);
    chk("wrap_rd_rng", {31'h0, err_rng}, 32'h1);

    // both errors: misaligned wins
    rd(OOR + 32'd1);
    chk("both_mis", {31'h0, err_mis}, 32'h1);
    chk("both_rng", {31'h0, err_rng}, 32'h0);

    // last word and back-to-back reads
    wr(LAST, 32'h1234_5678);
    r_en = 1'b1; r_addr = LAST;
    tick();
    chk("b2b_0", r_data, 32'h1234_5678);
    chk("last_rng", {31'h0, err_rng}, 32'h0);
    r_addr = 32'h0;
    tick();
    chk("b2b_1", r_data, 32'hA5A5_A5A5);
    r_addr = 32'h10;
    tick();
    chk("b2b_2", r_data, 32'h2222_2222);
    r_en = 1'b0;

`ifdef DMEM_WIPE_EN
    // wipe after reset, reads ignored while busy
    for (int i = 0; i < DEPTH; i++) wr(32'(4 * i), 32'(32'h100 + i));
    rd(32'h8);
    chk("fill_rd", r_data, 32'h102);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    r_en = 1'b1; r_addr = 32'h8;
    wait_busy(n);
    r_en = 1'b0;
    chk("rst_wipe_len", n, DEPTH);
    chk("busy_rd_ignored", r_data, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(32'(4 * i));
      chk($sformatf("wiped_%0d", i), r_data, 32'h0);
    end

    // reset while wiping word 7 restarts the full wipe
    for (int i = 0; i < DEPTH; i++) wr(32'(4 * i), 32'hFFFF_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    wait_busy(n);
    chk("mid_wipe_len", n, DEPTH);
    rd(LAST);
    chk("mid_wipe_last", r_data, 32'h0);

    // wipe on request
    wr(32'hC, 32'hCAFE_0000);
    rd(32'hC);
    chk("req_pre", r_data, 32'hCAFE_0000);
    wipe_req = 1'b1;
    tick();
    wipe_req = 1'b0;
    wait_busy(n);
    chk("req_wipe_len", n, DEPTH);
    rd(32'hC);
    chk("req_wiped", r_data, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem.md
# data_mem

Word-organised data memory that answers the core's data memory interface: it is the responder for the core's `mem_data_r_*` and `mem_data_w_*` request ports. Reads are registered with one-cycle latency. Writes commit on the accepting edge. Addresses are range-checked and alignment-checked. An optional zero-fill engine wipes the whole array after reset, or on request, so each program starts from known data.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index bits; depth = 2^ADDR_WIDTH words (4 KiB at default).
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- One clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_data_r_en` in 1: read request, sampled each edge.
- `mem_data_r_addr` in 32: byte address of the read.
- `mem_data_r_data` out 32: registered read data.
- `mem_data_w_en` in 1: write request, sampled each edge.
- `mem_data_w_addr` in 32: byte address of the write.
- `mem_data_w_data` in 32: write data, full word.
- `wipe_req` in 1: start zero-fill (only with `DMEM_WIPE_EN`).
- `busy` out 1: wipe in progress; requests ignored while high.
- `err_misaligned` out 1: one-cycle pulse, previous request had `addr[1:0] != 0`.
- `err_range` out 1: one-cycle pulse, previous request was outside `[BASE_ADDR, BASE_ADDR + 4*depth)`.

## Operation
- **Word index:** `idx = (addr - BASE_ADDR) >> 2`, truncated to ADDR_WIDTH bits after the range check. The subtraction is 32-bit unsigned; an address below BASE_ADDR wraps high and therefore fails the range check.
- **Read accepted:** `mem_data_r_en=1` and `busy=0`.
  - Valid address: `mem_data_r_data <= mem[idx]`.
  - Invalid address: `mem_data_r_data <= 0`, and the matching error flag pulses.
  - `mem_data_r_data` holds its value until the next accepted read.
- **Write accepted:** `mem_data_w_en=1` and `busy=0`, with a valid address: `mem[idx] <= mem_data_w_data`. An invalid write is dropped and the error flag pulses.
- **Read and write in the same cycle:** both are accepted. If they hit the same word, the read returns the old contents (read-before-write).
- **Both errors at once:** the misaligned check takes priority; only `err_misaligned` pulses.
- **Error flags:** each pulse lasts exactly one cycle and is aligned with the updated `mem_data_r_data`. Misaligned and out-of-range requests never modify storage.
- **FSM states:** IDLE, WIPE.
  - IDLE→WIPE: on reset release, or on `wipe_req=1` in IDLE.
  - In WIPE: writes `mem[cnt] <= 0`, then `cnt++`, one word per cycle.
  - WIPE→IDLE: after the edge that writes word depth-1.
  - `wipe_req` is ignored while in WIPE.
  - `busy = (state == WIPE)`.
- **Reset mid-wipe:** the counter returns to 0 and the wipe restarts after release. Reset never alters `mem` directly; clearing is done only by the wipe engine.

## Timing
- **Reset values:**
  - `mem_data_r_data = 0`, `err_misaligned = 0`, `err_range = 0`, wipe counter = 0.
  - With the macro, the state is WIPE and `busy = 1`. Without it, `busy = 0`.
- **Read latency:** a request sampled at edge N gives `mem_data_r_data` valid after edge N; the consumer samples it at edge N+1. The core must hold `r_en`/`addr` stable through edge N.
- **Write latency:** written data is visible to a read accepted at edge N+1.
- **Wipe duration:** exactly 2^ADDR_WIDTH cycles of `busy=1`. The first request accepted is the one at the edge where `busy` is sampled 0.
- **Back-to-back reads:** one per cycle, with no bubbles.

## Configuration
- Macro: `DMEM_WIPE_EN`.
- **Defined:** the wipe FSM, counter, `wipe_req` and `busy` are active as described above.
- **Undefined:**
  - No FSM and no counter.
  - `busy` is tied 0 and `wipe_req` is ignored.
  - Array contents after power-up are undefined (X in simulation) and unchanged by reset.
  - Requests are served from the first edge after reset release.

## Test plan
- **Basic write/read:** write 32'hDEAD_BEEF to 32'h0000_0010, then read 32'h0000_0010 next cycle → `mem_data_r_data = 32'hDEAD_BEEF` one cycle later; no error pulse.
- **Same-word collision:** mem[4] = 32'h1111_1111; read and write 32'h2222_2222 to 32'h0000_0010 in the same cycle → read returns 32'h1111_1111; a following read returns 32'h2222_2222.
- **Misaligned read:** read 32'h0000_0013 → `mem_data_r_data = 0`, `err_misaligned` high for 1 cycle. Misaligned write to 32'h0000_0012 → no storage change, confirmed by an aligned read.
- **Out of range:** write to 32'h0000_1000 at ADDR_WIDTH=10 → `err_range` pulses; mem[0] is unchanged (no alias write).
- **Wipe after reset (`DMEM_WIPE_EN`, ADDR_WIDTH=4):**
  - Fill all 16 words with nonzero data, assert `rst` for 2 cycles, release.
  - `busy` must stay high exactly 16 cycles.
  - Reads issued during `busy` are ignored (`mem_data_r_data` stays 0).
  - After `busy` falls, every word reads 0.
- **Reset mid-wipe:** assert `rst` while wiping word 7 → after release, `busy` lasts a full 16 cycles again.
